// File: rtl/alu_seq.sv
// alu_seq
//   Clocked ALU between the register-file read ports and the writeback mux.
//   Single-cycle arithmetic, logic and shift ops; iterative shift-add
//   multiply and restoring divide; registered PSR flag file whose carry
//   persists across ops (used by ADDC).
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_valid   operation request
//   in_ready   block can accept a request this cycle
//   op         0 ADD 1 ADDC 2 SUB 3 CMP 4 AND 5 OR 6 XOR 7 LSH 8 ASH
//              9 MULU 10 DIVU, 11-15 illegal
//   a, b       operands (b already extended by the decoder)
//   out_valid  result available; held with its data until out_ready
//   out_ready  consumer takes the result
//   result     primary result
//   result_hi  MULU high half / DIVU remainder, 0 otherwise
//   flags      PSR {N, Z, F, L, C} (bit 4 .. bit 0)
module alu_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [4:0]       flags
);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_ADDC = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_CMP  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_LSH  = 4'd7;
  localparam logic [3:0] OP_ASH  = 4'd8;
  localparam logic [3:0] OP_MULU = 4'd9;
  localparam logic [3:0] OP_DIVU = 4'd10;

  localparam int FC  = 0;
  localparam int FL  = 1;
  localparam int FF  = 2;
  localparam int FZ  = 3;
  localparam int FN  = 4;
  localparam int MSB = WIDTH - 1;
  localparam int CW  = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, ITER, RESULT} state_t;

  state_t           state_q, state_d;
  logic             armed_q;
  logic             accept;
  logic             iter_op;
  logic             last_step;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] lo_q;
  logic [WIDTH-1:0] opnd_q;
  logic             div_q;
  logic             bzero_q;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic [SHW:0]     sh_raw;
  logic [SHW:0]     sh_neg;
  logic [SHW:0]     sh_mag;
  logic             sh_right;
  logic [WIDTH-1:0] shl;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] sc_result;
  logic [4:0]       sc_flags;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_rs;
  logic [WIDTH:0]   div_diff;
  logic [WIDTH-1:0] step_acc;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] it_result;
  logic [4:0]       it_flags;

  // armed_q keeps in_ready low until the first edge after reset release.
  // A drained result and a new request may share an edge.
  assign accept    = in_valid & in_ready;
  assign iter_op   = (op == OP_MULU) | (op == OP_DIVU);
  assign in_ready  = armed_q & (state_q != ITER) & (~out_valid | out_ready);
  assign last_step = (state_q == ITER) & (cnt_q == CW'(1));

  // ADDC folds in the carry registered by an earlier op.
  // The carry out of the subtract is the borrow, i.e. a < b unsigned.
  assign add_full = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, (op == OP_ADDC) & flags[FC]};
  assign sub_full = {1'b0, a} - {1'b0, b};

  // Shift amount is the signed value of b[SHW:0]; negative means shift right.
  // Its magnitude can reach WIDTH only for a right shift, which must flush.
  assign sh_raw   = b[SHW:0];
  assign sh_neg   = -sh_raw;
  assign sh_right = sh_raw[SHW];
  assign sh_mag   = sh_right ? sh_neg : sh_raw;

  always_comb begin
    shl = a << sh_mag;
    if (sh_mag >= (SHW+1)'(WIDTH)) begin
      shr = ((op == OP_ASH) && a[MSB]) ? '1 : '0;
    end else if (op == OP_ASH) begin
      shr = $unsigned($signed(a) >>> sh_mag);
    end else begin
      shr = a >> sh_mag;
    end
  end

  // Result and next flags for every single-cycle op. Flags an op does not
  // define keep their registered value. MULU/DIVU codes fall into the
  // default arm here but never take this path.
  always_comb begin
    sc_result = '0;
    sc_flags  = flags;
    case (op)
      OP_ADD, OP_ADDC: begin
        sc_result    = add_full[WIDTH-1:0];
        sc_flags[FC] = add_full[WIDTH];
        sc_flags[FF] = (a[MSB] == b[MSB]) & (add_full[MSB] != a[MSB]);
      end
      OP_SUB: begin
        sc_result    = sub_full[WIDTH-1:0];
        sc_flags[FC] = sub_full[WIDTH];
        sc_flags[FF] = (a[MSB] != b[MSB]) & (sub_full[MSB] != a[MSB]);
      end
      OP_CMP: begin
        sc_flags[FL] = a < b;
        sc_flags[FN] = $signed(a) < $signed(b);
        sc_flags[FZ] = a == b;
      end
      OP_AND:         sc_result = a & b;
      OP_OR:          sc_result = a | b;
      OP_XOR:         sc_result = a ^ b;
      OP_LSH, OP_ASH: sc_result = sh_right ? shr : shl;
      default:        sc_flags  = '1;
    endcase
    if ((op <= OP_ASH) && (op != OP_CMP)) begin
      sc_flags[FZ] = sc_result == '0;
      sc_flags[FN] = sc_result[MSB];
    end
  end

  // One iteration step. Multiply: acc_q:lo_q is the running product with
  // the multiplier shifting out of lo_q. Divide: acc_q is the partial
  // remainder and quotient bits shift into lo_q as the dividend shifts out.
  // With a zero divisor the remainder naturally ends up equal to a.
  always_comb begin
    mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_rs   = {acc_q, lo_q[MSB]};
    div_diff = div_rs - {1'b0, opnd_q};
    if (div_q) begin
      if (div_diff[WIDTH]) begin
        step_acc = div_rs[WIDTH-1:0];
        step_lo  = {lo_q[MSB-1:0], 1'b0};
      end else begin
        step_acc = div_diff[WIDTH-1:0];
        step_lo  = {lo_q[MSB-1:0], 1'b1};
      end
    end else begin
      step_acc = mul_sum[WIDTH:1];
      step_lo  = {mul_sum[0], lo_q[MSB:1]};
    end
  end

  // Result and flags produced on the final iteration edge.
  always_comb begin
    it_result = step_lo;
    it_flags  = flags;
    if (!div_q) begin
      it_flags[FZ] = (step_acc == '0) & (step_lo == '0);
      it_flags[FC] = step_acc != '0;
    end else if (bzero_q) begin
      it_result    = '1;
      it_flags[FF] = 1'b1;
    end else begin
      it_flags[FZ] = step_lo == '0;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // RESULT behaves like IDLE for accepting, so back-to-back ops skip IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RESULT: begin
        if (accept) begin
          state_d = iter_op ? ITER : RESULT;
        end else if ((state_q == RESULT) && out_ready) begin
          state_d = IDLE;
        end
      end
      ITER: begin
        if (last_step) begin
          state_d = RESULT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath and output registers. Outputs change only on an accept of a
  // single-cycle op, on the final iteration, or when a result drains, so
  // they stay stable while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      armed_q   <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      flags     <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      div_q     <= 1'b0;
      bzero_q   <= 1'b0;
    end else begin
      armed_q <= 1'b1;
      if (accept) begin
        if (iter_op) begin
          out_valid <= 1'b0;
          cnt_q     <= CW'(WIDTH);
          acc_q     <= '0;
          lo_q      <= a;
          opnd_q    <= b;
          div_q     <= op == OP_DIVU;
          bzero_q   <= b == '0;
        end else begin
          out_valid <= 1'b1;
          result    <= sc_result;
          result_hi <= '0;
          flags     <= sc_flags;
        end
      end else if (state_q == ITER) begin
        cnt_q <= cnt_q - CW'(1);
        acc_q <= step_acc;
        lo_q  <= step_lo;
        if (last_step) begin
          out_valid <= 1'b1;
          result    <= it_result;
          result_hi <= step_acc;
          flags     <= it_flags;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq
//   Directed bench for alu_seq (WIDTH=16). A behavioural model computes the
//   expected result/flags for each accepted op from plain integer arithmetic
//   and queues them; a compare process checks the DUT against the queue head
//   on every cycle out_valid is high. Hand-computed literals pin the model.
module tb_alu_seq;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  op;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic [15:0] result_hi;
  logic [4:0]  flags;

  typedef struct packed {
    logic [15:0] r;
    logic [15:0] h;
    logic [4:0]  f;
  } exp_t;

  exp_t       expq[$];
  logic [4:0] mFlags;
  int         checks;
  int         errors;

  localparam int NT = 16;
  localparam logic [3:0]  T_OP [NT] = '{4'd0, 4'd1, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6, 4'd7,
                                        4'd8, 4'd9, 4'd10, 4'd3, 4'd15, 4'd9, 4'd10, 4'd2};
  localparam logic [15:0] T_A  [NT] = '{16'h1234, 16'hFFFF, 16'h0000, 16'h8000, 16'hF0F0,
                                        16'hF0F0, 16'hAAAA, 16'h0001, 16'h8000, 16'hFFFF,
                                        16'h0003, 16'h8000, 16'h5555, 16'h0000, 16'hFFFF,
                                        16'h0000};
  localparam logic [15:0] T_B  [NT] = '{16'h4321, 16'h0001, 16'h0000, 16'h0001, 16'h0F0F,
                                        16'h0F0F, 16'hAAAA, 16'h000F, 16'h001F, 16'hFFFF,
                                        16'h0007, 16'h0001, 16'h1111, 16'h1234, 16'h0000,
                                        16'h0001};

  alu_seq #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flags     (flags)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never completes.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: sim time expired, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h required %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour from the op definitions; updates the model PSR.
  function automatic void modelOp(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                                  output logic [15:0] r, output logic [15:0] h);
    int              u;
    int              sres;
    int              sx;
    int              sy;
    int              cin;
    int              sh;
    longint unsigned p;
    sx = int'($signed(x));
    sy = int'($signed(y));
    r  = 16'h0;
    h  = 16'h0;
    case (o)
      4'd0, 4'd1: begin
        cin       = (o == 4'd1) ? int'(mFlags[0]) : 0;
        u         = int'(x) + int'(y) + cin;
        r         = 16'(u);
        mFlags[0] = u > 65535;
        sres      = sx + sy + cin;
        mFlags[2] = (sres > 32767) || (sres < -32768);
      end
      4'd2: begin
        r         = x - y;
        mFlags[0] = x < y;
        sres      = sx - sy;
        mFlags[2] = (sres > 32767) || (sres < -32768);
      end
      4'd3: begin
        mFlags[1] = x < y;
        mFlags[4] = sx < sy;
        mFlags[3] = x == y;
      end
      4'd4: r = x & y;
      4'd5: r = x | y;
      4'd6: r = x ^ y;
      4'd7, 4'd8: begin
        sh = int'(y[4:0]);
        if (sh > 15) sh = sh - 32;
        if (sh >= 0) r = 16'(int'(x) << sh);
        else if (o == 4'd7) r = (-sh >= 16) ? 16'h0 : 16'(int'(x) >> (-sh));
        else r = 16'(sx >>> (-sh));
      end
      4'd9: begin
        p         = longint'(x) * longint'(y);
        r         = p[15:0];
        h         = p[31:16];
        mFlags[3] = p == 0;
        mFlags[0] = h != 16'h0;
      end
      4'd10: begin
        if (y == 16'h0) begin
          r         = 16'hFFFF;
          h         = x;
          mFlags[2] = 1'b1;
        end else begin
          r         = x / y;
          h         = x % y;
          mFlags[3] = r == 16'h0;
        end
      end
      default: mFlags = 5'b11111;
    endcase
    if (o <= 4'd8 && o != 4'd3) begin
      mFlags[3] = r == 16'h0;
      mFlags[4] = r[15];
    end
  endfunction

  // Present a request and hold it until accepted; queue the model's answer.
  task automatic issue(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y);
    int          w;
    exp_t        e;
    logic [15:0] r;
    logic [15:0] h;
    w        = 0;
    op       = o;
    a        = x;
    b        = y;
    in_valid = 1'b1;
    while (!in_ready && w < 50) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept: in_ready=%0b after %0d cycles, required 1", in_ready, w);
    end else begin
      @(posedge clk);
      modelOp(o, x, y, r, h);
      e.r = r;
      e.h = h;
      e.f = mFlags;
      expq.push_back(e);
      #1;
    end
    in_valid = 1'b0;
  endtask

  // Count edges from the accept edge until out_valid is seen (bounded).
  task automatic waitResult(output int lat, output int rdy);
    lat = 1;
    rdy = 0;
    while (!out_valid && lat < 64) begin
      if (in_ready) rdy++;
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic applyStimulus(input logic [3:0] o, input logic [15:0] x, input logic [15:0] y,
                               output int lat);
    int rdy;
    issue(o, x, y);
    waitResult(lat, rdy);
  endtask

  // Compare process: every cycle a result is presented it must match the
  // oldest outstanding expectation; it retires when the consumer takes it.
  always @(negedge clk) begin
    if (reset_n && out_valid) begin
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected out_valid: got 1 required 0 at %0t", $time);
      end else begin
        checkOutput("model result", 32'(result), 32'(expq[0].r));
        checkOutput("model result_hi", 32'(result_hi), 32'(expq[0].h));
        checkOutput("model flags", 32'(flags), 32'(expq[0].f));
        if (out_ready) void'(expq.pop_front());
      end
    end
  end

  initial begin
    int lat;
    int rdy;
    int cnt;
    checks    = 0;
    errors    = 0;
    mFlags    = 5'b0;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 4'd0;
    a         = 16'h0;
    b         = 16'h0;

    // Reset values and the one-cycle in_ready delay after release.
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset result", 32'(result), 32'd0);
    checkOutput("reset result_hi", 32'(result_hi), 32'd0);
    checkOutput("reset flags", 32'(flags), 32'd0);
    reset_n = 1'b1;
    #1;
    checkOutput("in_ready before first clock", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("in_ready after release", 32'(in_ready), 32'd1);

    // ADD with signed overflow.
    applyStimulus(4'd0, 16'h7FFF, 16'h0001, lat);
    checkOutput("add latency", 32'(lat), 32'd1);
    checkOutput("add result", 32'(result), 32'h8000);
    checkOutput("add flags", 32'(flags), 32'b10100);

    // Carry out, then ADDC consuming it.
    applyStimulus(4'd0, 16'hFFFF, 16'h0001, lat);
    checkOutput("add carry result", 32'(result), 32'h0);
    checkOutput("add carry flags", 32'(flags), 32'b01001);
    applyStimulus(4'd1, 16'h0000, 16'h0000, lat);
    checkOutput("addc result", 32'(result), 32'h0001);
    checkOutput("addc flags", 32'(flags), 32'b00000);

    // CMP leaves C/F alone; SUB borrow.
    applyStimulus(4'd3, 16'hFFFF, 16'h0001, lat);
    checkOutput("cmp result", 32'(result), 32'h0);
    checkOutput("cmp flags", 32'(flags), 32'b10000);
    applyStimulus(4'd2, 16'h0003, 16'h0005, lat);
    checkOutput("sub result", 32'(result), 32'hFFFE);
    checkOutput("sub flags", 32'(flags), 32'b10001);

    // MULU with the consumer stalled.
    issue(4'd9, 16'h1234, 16'h0100);
    out_ready = 1'b0;
    waitResult(lat, rdy);
    checkOutput("mulu latency", 32'(lat), 32'd17);
    checkOutput("mulu in_ready while busy", 32'(rdy), 32'd0);
    checkOutput("mulu result", 32'(result), 32'h3400);
    checkOutput("mulu result_hi", 32'(result_hi), 32'h0012);
    checkOutput("mulu flags", 32'(flags), 32'b10001);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall out_valid", 32'(out_valid), 32'd1);
      checkOutput("stall in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("drain out_valid", 32'(out_valid), 32'd0);

    // DIVU, normal and divide-by-zero.
    applyStimulus(4'd10, 16'd100, 16'd7, lat);
    checkOutput("divu latency", 32'(lat), 32'd17);
    checkOutput("divu quotient", 32'(result), 32'd14);
    checkOutput("divu remainder", 32'(result_hi), 32'd2);
    checkOutput("divu flags", 32'(flags), 32'b10001);
    applyStimulus(4'd10, 16'd5, 16'd0, lat);
    checkOutput("div0 latency", 32'(lat), 32'd17);
    checkOutput("div0 quotient", 32'(result), 32'hFFFF);
    checkOutput("div0 remainder", 32'(result_hi), 32'd5);
    checkOutput("div0 flags", 32'(flags), 32'b10101);

    // Shifts right by one and by the full width.
    applyStimulus(4'd7, 16'h8001, 16'hFFFF, lat);
    checkOutput("lsh right result", 32'(result), 32'h4000);
    checkOutput("lsh right flags", 32'(flags), 32'b00101);
    applyStimulus(4'd8, 16'h8001, 16'hFFFF, lat);
    checkOutput("ash right result", 32'(result), 32'hC000);
    applyStimulus(4'd7, 16'h8001, 16'h0010, lat);
    checkOutput("lsh by -16 result", 32'(result), 32'h0);
    checkOutput("lsh by -16 flags", 32'(flags), 32'b01101);
    applyStimulus(4'd8, 16'h8001, 16'h0010, lat);
    checkOutput("ash by -16 result", 32'(result), 32'hFFFF);

    // Illegal op.
    applyStimulus(4'd12, 16'h1234, 16'h5678, lat);
    checkOutput("illegal latency", 32'(lat), 32'd1);
    checkOutput("illegal result", 32'(result), 32'h0);
    checkOutput("illegal flags", 32'(flags), 32'b11111);

    // Back-to-back table, checked by the model.
    for (int i = 0; i < NT; i++) begin
      applyStimulus(T_OP[i], T_A[i], T_B[i], lat);
      checkOutput("table latency", 32'(lat), (T_OP[i] == 4'd9 || T_OP[i] == 4'd10) ? 32'd17 : 32'd1);
    end

    // Reset asserted in the middle of a multiply.
    issue(4'd9, 16'h00FF, 16'h00FF);
    repeat (5) @(posedge clk);
    #3;
    reset_n = 1'b0;
    expq.delete();
    mFlags = 5'b0;
    #1;
    checkOutput("mid reset out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid reset result", 32'(result), 32'h0);
    checkOutput("mid reset flags", 32'(flags), 32'h0);
    checkOutput("mid reset in_ready", 32'(in_ready), 32'd0);
    #5;
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) cnt++;
    end
    checkOutput("no output after reset", 32'(cnt), 32'd0);

    // Carry was cleared by reset.
    applyStimulus(4'd1, 16'h0001, 16'h0001, lat);
    checkOutput("addc after reset", 32'(result), 32'h0002);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("all results retired", 32'(expq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
